// File: rtl/alu_pkg.sv
// Shared ALU constants: datapath width and the ALU-control opcode encoding.
package alu_pkg;

  localparam int ALU_W = 32;

  localparam logic [3:0] CTL_AND = 4'b0000;
  localparam logic [3:0] CTL_OR  = 4'b0001;
  localparam logic [3:0] CTL_ADD = 4'b0010;
  localparam logic [3:0] CTL_SUB = 4'b0110;
  localparam logic [3:0] CTL_SLT = 4'b0111;
  localparam logic [3:0] CTL_NOR = 4'b1100;
  localparam logic [3:0] CTL_XOR = 4'b1101;

endpackage

// File: rtl/alu_addsub.sv
// Shared adder for ADD/SUB/SLT. Subtraction is a + ~b + 1; ovf is the
// two's-complement overflow of whichever operation was performed.
module alu_addsub
  import alu_pkg::*;
(
  input  logic signed [ALU_W-1:0] a,
  input  logic signed [ALU_W-1:0] b,
  input  logic                    sub,
  output logic signed [ALU_W-1:0] sum,
  output logic                    ovf
);

  logic signed [ALU_W-1:0] b_op;
  logic        [ALU_W-1:0] cin;

  assign b_op = sub ? ~b : b;
  assign cin  = {{(ALU_W-1){1'b0}}, sub};
  assign sum  = $signed($unsigned(a) + $unsigned(b_op) + cin);

  // Overflow: both addends share a sign that the result does not.
  assign ovf  = (a[ALU_W-1] == b_op[ALU_W-1]) && (sum[ALU_W-1] != a[ALU_W-1]);

endmodule

// File: rtl/alu.sv
// 32-bit MIPS ALU: combinational op select and zero detect, followed by
// one register stage holding the result and the zero flag.
module alu
  import alu_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic [3:0]              ctl,
  input  logic signed [ALU_W-1:0] a,
  input  logic signed [ALU_W-1:0] b,
  output logic [ALU_W-1:0]        out,
  output logic                    z
);

  // Signed less-than corrected for overflow of the difference.
  function automatic logic signed_less(input logic d_msb, input logic ovf);
    return d_msb ^ ovf;
  endfunction

  logic                    sub_p0;
  logic signed [ALU_W-1:0] sum_p0;
  logic                    ovf_p0;
  logic [ALU_W-1:0]        res_p0;
  logic                    zero_p0;

  assign sub_p0 = (ctl == CTL_SUB) || (ctl == CTL_SLT);

  alu_addsub u_addsub (
    .a   (a),
    .b   (b),
    .sub (sub_p0),
    .sum (sum_p0),
    .ovf (ovf_p0)
  );

  // Operation select; unused codes yield zero.
  always_comb begin
    res_p0 = '0;
    unique case (ctl)
      CTL_ADD,
      CTL_SUB: res_p0 = sum_p0;
      CTL_AND: res_p0 = a & b;
      CTL_OR:  res_p0 = a | b;
      CTL_NOR: res_p0 = ~(a | b);
      CTL_XOR: res_p0 = a ^ b;
      CTL_SLT: res_p0 = {{(ALU_W-1){1'b0}}, signed_less(sum_p0[ALU_W-1], ovf_p0)};
      default: res_p0 = '0;
    endcase
  end

  assign zero_p0 = (res_p0 == '0);

  // ---- stage p0 -> registered outputs ----
  // Result/flag register; reset wins over any operation in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      out <= '0;
      z   <= 1'b1;
    end else begin
      out <= res_p0;
      z   <= zero_p0;
    end
  end

endmodule

// File: tb/tb_alu.sv
// Scoreboard bench for alu: the driver pushes the expected out/z for every
// cycle it drives; the monitor pops and compares after each rising edge.
module tb_alu;
  import alu_pkg::*;

  typedef struct {
    logic [31:0] out;
    logic        z;
    string       name;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  ctl;
  logic signed [31:0] a;
  logic signed [31:0] b;
  logic [31:0] out;
  logic        z;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   done   = 1'b0;

  alu dut (
    .clk   (clk),
    .reset (reset),
    .ctl   (ctl),
    .a     (a),
    .b     (b),
    .out   (out),
    .z     (z)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs on the falling edge and queue its expected result.
  task automatic step(input logic rst_i, input logic [3:0] ctl_i,
                      input logic [31:0] a_i, input logic [31:0] b_i,
                      input logic [31:0] eo, input logic ez, input string nm);
    exp_t e;
    @(negedge clk);
    reset = rst_i;
    ctl   = ctl_i;
    a     = a_i;
    b     = b_i;
    e.out  = eo;
    e.z    = ez;
    e.name = nm;
    exp_q.push_back(e);
  endtask

  // Monitor: the DUT presents a fresh result after every rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (out !== e.out || z !== e.z) begin
          errors++;
          $display("FAIL %s: out=%h z=%b expected out=%h z=%b",
                   e.name, out, z, e.out, e.z);
        end
      end
    end
  end

  // Directed stimulus with hand-computed expectations.
  initial begin
    reset = 1'b1;
    ctl   = CTL_ADD;
    a     = '0;
    b     = '0;

    step(1'b1, CTL_ADD, 32'd0, 32'd0, 32'h0, 1'b1, "reset0");
    step(1'b1, CTL_ADD, 32'd0, 32'd0, 32'h0, 1'b1, "reset1");
    step(1'b0, CTL_ADD, 32'd2, 32'd2, 32'd4, 1'b0, "add_2_2");
    step(1'b0, CTL_SUB, 32'd4, 32'd2, 32'd2, 1'b0, "sub_4_2");
    step(1'b0, CTL_SUB, 32'd15, 32'd126, 32'hFFFFFF91, 1'b0, "sub_15_126");
    step(1'b0, CTL_OR,  32'hFFFF1010, 32'h0000FFFF, 32'hFFFFFFFF, 1'b0, "or");
    step(1'b0, CTL_NOR, 32'hFFFF1010, 32'h0000FFFF, 32'h00000000, 1'b1, "nor");
    step(1'b0, CTL_AND, 32'hFFFF1010, 32'h0000FFFF, 32'h00001010, 1'b0, "and");
    // 1010100 = 0xF69B4, 100000 = 0x186A0, xor = 0xEEF14
    step(1'b0, CTL_XOR, 32'd1010100, 32'd100000, 32'h000EEF14, 1'b0, "xor");
    step(1'b0, CTL_SLT, 32'd100000, 32'd10001, 32'h0, 1'b1, "slt_pos_ge");
    step(1'b0, CTL_SLT, 32'hFFFFFFF9, 32'd6, 32'h1, 1'b0, "slt_neg7_6");
    step(1'b0, CTL_SLT, 32'h4A1BA35D, 32'h98782A64, 32'h0, 1'b1, "slt_ovf1");
    step(1'b0, CTL_SLT, 32'h7D8C01D7, 32'hB24D0744, 32'h0, 1'b1, "slt_ovf2");
    step(1'b0, CTL_SLT, 32'hA1A538C4, 32'h2C6F2B94, 32'h1, 1'b0, "slt_ovf3");
    step(1'b0, CTL_SLT, 32'h4270AA12, 32'hA2C98214, 32'h0, 1'b1, "slt_ovf4");
    step(1'b0, 4'b1111, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 1'b1, "ctl_unused");
    step(1'b0, CTL_ADD, 32'hFFFFFFFF, 32'd1, 32'h0, 1'b1, "add_wrap");
    step(1'b0, CTL_ADD, 32'h7FFFFFFF, 32'd1, 32'h80000000, 1'b0, "add_ovf_wrap");
    step(1'b1, CTL_ADD, 32'd2, 32'd2, 32'h0, 1'b1, "reset_priority");
    step(1'b0, CTL_ADD, 32'd10, 32'd20, 32'd30, 1'b0, "b2b_add");
    step(1'b0, CTL_SUB, 32'd7, 32'd7, 32'h0, 1'b1, "b2b_sub_zero");
    step(1'b0, CTL_SLT, 32'h80000000, 32'h7FFFFFFF, 32'h1, 1'b0, "b2b_slt_min_max");
    step(1'b0, CTL_OR,  32'h00F0F000, 32'h0F000F00, 32'h0FF0FF00, 1'b0, "b2b_or");
    step(1'b0, 4'b0011, 32'h12345678, 32'h9ABCDEF0, 32'h0, 1'b1, "ctl_0011");

    // Let the last result drain through the monitor, bounded.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: pending=%0d expected pending=0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    done = 1'b1;
    $finish;
  end

  // Global time bound so the run always ends on its own.
  initial begin
    #100000;
    if (!done) begin
      $display("FAIL timeout: done=0 expected done=1");
      $fatal(1, "timeout");
    end
  end

endmodule
